// File: rtl/extend_pkg.sv
// ---------------------------------------------------------------------------
// extend_pkg
// Shared definitions for the pipelined immediate extender.
//   imm_src_e : immediate format select driven by the decoder
//   IMM_SRC_W : width of the format select field
// Encoding 3'b111 is deliberately left out of the enum. The extender treats
// it as an unsupported format and flags the entry as illegal.
// ---------------------------------------------------------------------------
package extend_pkg;

  localparam int IMM_SRC_W = 3;

  typedef enum logic [IMM_SRC_W-1:0] {
    IMM_I  = 3'd0,
    IMM_S  = 3'd1,
    IMM_B  = 3'd2,
    IMM_J  = 3'd3,
    IMM_U  = 3'd4,
    IMM_Z  = 3'd5,
    IMM_SH = 3'd6
  } imm_src_e;

endpackage

// File: rtl/extend_stage.sv
// ---------------------------------------------------------------------------
// extend_stage
// One elastic register slice with a valid/ready handshake and flush.
//   clk_i, rst_ni      : clock, asynchronous active-low reset
//   flush_i            : clears the held entry on the next rising edge
//   valid_i, ready_o   : upstream side of the handshake
//   data_i             : payload, W bits wide
//   valid_o, ready_i   : downstream side of the handshake
//   data_o             : registered payload
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high. The producer holds valid and data stable until that edge. The
// slice is ready whenever it is empty or its entry leaves on the same edge.
// That makes ready combinational from ready_i, so a chain of slices streams
// at one entry per cycle.
// ---------------------------------------------------------------------------
module extend_stage #(
  parameter int W = 8
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         flush_i,
  input  logic         valid_i,
  output logic         ready_o,
  input  logic [W-1:0] data_i,
  output logic         valid_o,
  input  logic         ready_i,
  output logic [W-1:0] data_o
);

  logic         valid_q, valid_d;
  logic [W-1:0] data_q, data_d;

  assign ready_o = !valid_q || ready_i;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (ready_o) begin
      valid_d = valid_i;
    end
    if (ready_o && valid_i) begin
      data_d = data_i;
    end
    // Flush wins over everything. An entry leaving downstream on this edge
    // has already been taken by the consumer. An entry arriving on this edge
    // is dropped.
    if (flush_i) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;

endmodule

// File: rtl/extend_unit_pipe.sv
// ---------------------------------------------------------------------------
// extend_unit_pipe
// Immediate extender for the ID stage. It decodes the immediate from the
// full instruction word, extends it to XLEN, and passes it through STAGES
// elastic register slices together with a sideband tag and an illegal flag.
//   i_clk, i_rst_n     : clock, asynchronous active-low reset
//   i_flush            : drop every in-flight entry
//   i_valid, o_ready   : upstream handshake (transfer when both are high)
//   i_instr            : raw 32-bit instruction word
//   i_imm_src          : format select (extend_pkg::imm_src_e, 3'b111 = illegal)
//   i_tag              : sideband, carried through unchanged
//   o_valid, i_ready   : downstream handshake (transfer when both are high)
//   o_imm              : extended immediate
//   o_tag              : tag of the output entry
//   o_illegal          : entry was decoded from an unsupported format
// Legal parameters: XLEN is 32 or 64, and STAGES is 1..3.
// ---------------------------------------------------------------------------
module extend_unit_pipe
  import extend_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int STAGES = 1,
  parameter int TAG_W  = 5
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_flush,
  input  logic                 i_valid,
  output logic                 o_ready,
  input  logic [31:0]          i_instr,
  input  logic [IMM_SRC_W-1:0] i_imm_src,
  input  logic [TAG_W-1:0]     i_tag,
  output logic                 o_valid,
  input  logic                 i_ready,
  output logic [XLEN-1:0]      o_imm,
  output logic [TAG_W-1:0]     o_tag,
  output logic                 o_illegal
);

  localparam int PW = XLEN + TAG_W + 1;

  logic [31:0]     raw;
  logic            sext;
  logic [XLEN-1:0] imm_dec;
  logic            illegal_dec;

  // Every format is first built as a 32-bit value. Sign-extending formats
  // already carry instr[31] up to bit 31, so widening to XLEN only needs to
  // repeat bit 31 of that value.
  always_comb begin
    raw         = '0;
    sext        = 1'b0;
    illegal_dec = 1'b0;
    case (i_imm_src)
      IMM_I: begin
        raw  = {{20{i_instr[31]}}, i_instr[31:20]};
        sext = 1'b1;
      end
      IMM_S: begin
        raw  = {{20{i_instr[31]}}, i_instr[31:25], i_instr[11:7]};
        sext = 1'b1;
      end
      IMM_B: begin
        raw  = {{19{i_instr[31]}}, i_instr[31], i_instr[7], i_instr[30:25],
                i_instr[11:8], 1'b0};
        sext = 1'b1;
      end
      IMM_J: begin
        raw  = {{11{i_instr[31]}}, i_instr[31], i_instr[19:12], i_instr[20],
                i_instr[30:21], 1'b0};
        sext = 1'b1;
      end
      IMM_U: begin
        raw  = {i_instr[31:12], 12'b0};
        sext = 1'b1;
      end
      IMM_Z: begin
        raw = {27'b0, i_instr[19:15]};
      end
      IMM_SH: begin
        // RV64 shifts use a 6-bit shamt, so instr[25] joins the field.
        if (XLEN == 64) begin
          raw = {26'b0, i_instr[25:20]};
        end else begin
          raw = {27'b0, i_instr[24:20]};
        end
      end
      default: begin
        illegal_dec = 1'b1;
      end
    endcase
    imm_dec = sext ? XLEN'($signed(raw)) : XLEN'(raw);
  end

  // Slice k reads element k and writes element k+1. Element 0 is the decoder
  // side, and element STAGES is the output port side.
  logic [STAGES:0] valid_c;
  logic [STAGES:0] ready_c;
  logic [PW-1:0]   data_c [STAGES+1];

  assign valid_c[0]      = i_valid;
  assign data_c[0]       = {illegal_dec, i_tag, imm_dec};
  assign ready_c[STAGES] = i_ready;
  assign o_ready         = ready_c[0];

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    extend_stage #(
      .W (PW)
    ) u_stage (
      .clk_i   (i_clk),
      .rst_ni  (i_rst_n),
      .flush_i (i_flush),
      .valid_i (valid_c[k]),
      .ready_o (ready_c[k]),
      .data_i  (data_c[k]),
      .valid_o (valid_c[k+1]),
      .ready_i (ready_c[k+1]),
      .data_o  (data_c[k+1])
    );
  end

  assign o_valid                   = valid_c[STAGES];
  assign {o_illegal, o_tag, o_imm} = data_c[STAGES];

endmodule

// File: tb/tb_extend_unit_pipe.sv
// ---------------------------------------------------------------------------
// tb_extend_unit_pipe
// Directed bench with three instances of the extender:
//   u_a : XLEN=32, STAGES=1  -> decode formats, single-cycle latency
//   u_b : XLEN=64, STAGES=2  -> 64-bit extension, backpressure and ordering
//   u_c : XLEN=32, STAGES=3  -> flush, illegal format, reset with a full pipe
// Inputs change 1 time unit after the rising edge. Outputs are sampled at that
// same point, or 1 time unit later when a combinational o_ready is needed.
// Valid/ready semantics: a transfer happens on a rising edge where valid and
// ready are both high.
// ---------------------------------------------------------------------------
module tb_extend_unit_pipe;

  // ---------------- clock / reset ----------------
  logic i_clk = 1'b0;
  logic i_rst_n;
  always #5 i_clk = ~i_clk;

  // ---------------- instance A signals ----------------
  logic        a_flush, a_valid, a_ready, a_o_ready, a_o_valid, a_o_illegal;
  logic [31:0] a_instr, a_o_imm;
  logic [2:0]  a_src;
  logic [4:0]  a_tag, a_o_tag;

  // ---------------- instance B signals ----------------
  logic        b_flush, b_valid, b_ready, b_o_ready, b_o_valid, b_o_illegal;
  logic [31:0] b_instr;
  logic [63:0] b_o_imm;
  logic [2:0]  b_src;
  logic [4:0]  b_tag, b_o_tag;

  // ---------------- instance C signals ----------------
  logic        c_flush, c_valid, c_ready, c_o_ready, c_o_valid, c_o_illegal;
  logic [31:0] c_instr, c_o_imm;
  logic [2:0]  c_src;
  logic [4:0]  c_tag, c_o_tag;

  extend_unit_pipe #(.XLEN(32), .STAGES(1), .TAG_W(5)) u_a (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_flush(a_flush), .i_valid(a_valid),
    .o_ready(a_o_ready), .i_instr(a_instr), .i_imm_src(a_src), .i_tag(a_tag),
    .o_valid(a_o_valid), .i_ready(a_ready), .o_imm(a_o_imm), .o_tag(a_o_tag),
    .o_illegal(a_o_illegal)
  );

  extend_unit_pipe #(.XLEN(64), .STAGES(2), .TAG_W(5)) u_b (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_flush(b_flush), .i_valid(b_valid),
    .o_ready(b_o_ready), .i_instr(b_instr), .i_imm_src(b_src), .i_tag(b_tag),
    .o_valid(b_o_valid), .i_ready(b_ready), .o_imm(b_o_imm), .o_tag(b_o_tag),
    .o_illegal(b_o_illegal)
  );

  extend_unit_pipe #(.XLEN(32), .STAGES(3), .TAG_W(5)) u_c (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_flush(c_flush), .i_valid(c_valid),
    .o_ready(c_o_ready), .i_instr(c_instr), .i_imm_src(c_src), .i_tag(c_tag),
    .o_valid(c_o_valid), .i_ready(c_ready), .o_imm(c_o_imm), .o_tag(c_o_tag),
    .o_illegal(c_o_illegal)
  );

  // ---------------- scoreboard ----------------
  int         n_checks = 0;
  int         n_fail   = 0;
  logic [4:0] exp_q[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // ---------------- driver helpers ----------------
  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  // I-format word whose immediate equals the tag value.
  function automatic logic [31:0] mk_i(input logic [4:0] t);
    return {7'b0, t, 20'h00093};
  endfunction

  // Directed vectors for instance A (XLEN=32).
  logic [31:0] t_instr [8];
  logic [2:0]  t_src   [8];
  logic [31:0] t_imm   [8];
  logic        t_ill   [8];

  initial begin
    int         acc;
    logic [4:0] next_tag;
    logic [4:0] exp_tag;

    t_instr[0] = 32'hFFF00093; t_src[0] = 3'd0; t_imm[0] = 32'hFFFFFFFF; t_ill[0] = 1'b0;
    t_instr[1] = 32'hFE000EE3; t_src[1] = 3'd2; t_imm[1] = 32'hFFFFFFFC; t_ill[1] = 1'b0;
    t_instr[2] = 32'h0080006F; t_src[2] = 3'd3; t_imm[2] = 32'h00000008; t_ill[2] = 1'b0;
    t_instr[3] = {7'b1000000, 5'd2, 5'd3, 3'b010, 5'b00001, 7'h23};
    t_src[3] = 3'd1; t_imm[3] = 32'hFFFFF801; t_ill[3] = 1'b0;
    t_instr[4] = {12'hABC, 5'b10110, 3'b101, 5'd1, 7'h73};
    t_src[4] = 3'd5; t_imm[4] = 32'h00000016; t_ill[4] = 1'b0;
    t_instr[5] = {6'b000000, 6'b110101, 5'd3, 3'b001, 5'd2, 7'h13};
    t_src[5] = 3'd6; t_imm[5] = 32'h00000015; t_ill[5] = 1'b0;
    t_instr[6] = 32'hFFFFFFFF; t_src[6] = 3'd7; t_imm[6] = 32'h00000000; t_ill[6] = 1'b1;
    t_instr[7] = 32'h800000B7; t_src[7] = 3'd4; t_imm[7] = 32'h80000000; t_ill[7] = 1'b0;

    i_rst_n = 1'b0;
    a_flush = 0; a_valid = 0; a_ready = 1; a_instr = '0; a_src = '0; a_tag = '0;
    b_flush = 0; b_valid = 0; b_ready = 1; b_instr = '0; b_src = '0; b_tag = '0;
    c_flush = 0; c_valid = 0; c_ready = 1; c_instr = '0; c_src = '0; c_tag = '0;

    // ---------------- reset state ----------------
    tick(); tick();
    chk("rst_a_valid", a_o_valid, 0);
    chk("rst_a_imm", a_o_imm, 0);
    chk("rst_a_tag", a_o_tag, 0);
    chk("rst_a_illegal", a_o_illegal, 0);
    chk("rst_b_imm", b_o_imm, 0);
    chk("rst_c_valid", c_o_valid, 0);
    i_rst_n = 1'b1;
    tick();
    chk("rst_a_ready", a_o_ready, 1);
    chk("rst_c_ready", c_o_ready, 1);

    // ---------------- A: decode formats, 1-cycle latency ----------------
    for (int i = 0; i < 8; i++) begin
      a_valid = 1; a_instr = t_instr[i]; a_src = t_src[i]; a_tag = 5'(i + 1);
      #1;
      chk("a_ready", a_o_ready, 1);
      tick();
      chk("a_valid", a_o_valid, 1);
      chk("a_imm", a_o_imm, t_imm[i]);
      chk("a_tag", a_o_tag, 64'(i + 1));
      chk("a_illegal", a_o_illegal, t_ill[i]);
    end
    a_valid = 0;
    tick();
    chk("a_drain", a_o_valid, 0);

    // ---------------- B: XLEN=64, STAGES=2, streaming ----------------
    b_ready = 1; b_valid = 1; b_instr = 32'h800000B7; b_src = 3'd4; b_tag = 5'd1;
    tick();
    b_instr = 32'h123450B7; b_src = 3'd4; b_tag = 5'd2;
    chk("b_latency", b_o_valid, 0);
    tick();
    chk("b_u_neg_valid", b_o_valid, 1);
    chk("b_u_neg_imm", b_o_imm, 64'hFFFFFFFF80000000);
    chk("b_u_neg_tag", b_o_tag, 1);
    b_instr = {6'b000000, 6'b110101, 5'd3, 3'b001, 5'd2, 7'h13}; b_src = 3'd6; b_tag = 5'd3;
    tick();
    chk("b_u_pos_imm", b_o_imm, 64'h0000000012345000);
    chk("b_u_pos_tag", b_o_tag, 2);
    b_instr = 32'hFFF00093; b_src = 3'd0; b_tag = 5'd4;
    tick();
    chk("b_sh64_imm", b_o_imm, 64'h35);
    b_valid = 0;
    tick();
    chk("b_i64_imm", b_o_imm, 64'hFFFFFFFFFFFFFFFF);
    chk("b_i64_tag", b_o_tag, 4);
    tick();
    chk("b_drain", b_o_valid, 0);

    // ---------------- B: backpressure, capacity 2 ----------------
    b_ready = 0; next_tag = 5'd1; acc = 0;
    for (int i = 0; i < 6; i++) begin
      b_valid = 1; b_tag = next_tag; b_instr = mk_i(next_tag); b_src = 3'd0;
      #1;
      if (b_o_ready) begin
        exp_q.push_back(next_tag);
        acc++;
        next_tag++;
      end
      tick();
    end
    chk("bp_accepted", 64'(acc), 2);
    chk("bp_ready_low", b_o_ready, 0);
    chk("bp_hold_valid", b_o_valid, 1);
    chk("bp_hold_tag", b_o_tag, 1);
    chk("bp_hold_imm", b_o_imm, 1);
    tick();
    chk("bp_hold_tag2", b_o_tag, 1);

    b_ready = 1;
    for (int i = 0; i < 4; i++) begin
      b_valid = (next_tag <= 5'd4); b_tag = next_tag; b_instr = mk_i(next_tag);
      #1;
      exp_tag = (exp_q.size() > 0) ? exp_q.pop_front() : 5'h1F;
      chk("bp_out_valid", b_o_valid, 1);
      chk("bp_out_tag", b_o_tag, exp_tag);
      chk("bp_out_imm", b_o_imm, 64'(exp_tag));
      if (b_valid && b_o_ready) begin
        exp_q.push_back(next_tag);
        next_tag++;
      end
      tick();
    end
    b_valid = 0;
    chk("bp_after_valid", b_o_valid, 0);
    chk("bp_queue_empty", 64'(exp_q.size()), 0);

    // ---------------- C: fill STAGES=3, then flush ----------------
    c_ready = 0;
    for (int i = 0; i < 3; i++) begin
      c_valid = 1; c_tag = 5'(i + 1); c_instr = mk_i(5'(i + 1)); c_src = 3'd0;
      #1;
      chk("c_fill_ready", c_o_ready, 1);
      tick();
    end
    c_tag = 5'd4; c_instr = mk_i(5'd4); c_flush = 1;
    #1;
    chk("c_full_ready", c_o_ready, 0);
    chk("c_full_valid", c_o_valid, 1);
    chk("c_full_tag", c_o_tag, 1);
    tick();
    c_flush = 0; c_valid = 0;
    chk("c_flush_valid", c_o_valid, 0);
    c_ready = 1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("c_flush_empty", c_o_valid, 0);
    end

    // Push and flush on the same edge: the entry is discarded.
    c_valid = 1; c_tag = 5'd7; c_instr = mk_i(5'd7); c_flush = 1;
    #1;
    chk("c_flushpush_ready", c_o_ready, 1);
    tick();
    c_valid = 0; c_flush = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("c_flushpush_empty", c_o_valid, 0);
    end

    // Illegal format through three stages.
    c_valid = 1; c_instr = 32'hFFFFFFFF; c_src = 3'd7; c_tag = 5'd9;
    tick();
    c_valid = 0;
    tick();
    chk("c_ill_latency", c_o_valid, 0);
    tick();
    chk("c_ill_valid", c_o_valid, 1);
    chk("c_ill_imm", c_o_imm, 0);
    chk("c_ill_flag", c_o_illegal, 1);
    chk("c_ill_tag", c_o_tag, 9);
    tick();
    chk("c_ill_drain", c_o_valid, 0);

    // ---------------- C: reset with a full pipe ----------------
    c_ready = 0; c_src = 3'd0;
    for (int i = 0; i < 3; i++) begin
      c_valid = 1; c_tag = 5'(i + 1); c_instr = mk_i(5'(i + 1));
      tick();
    end
    c_valid = 0;
    chk("c_prerst_valid", c_o_valid, 1);
    chk("c_prerst_tag", c_o_tag, 1);
    #3;
    i_rst_n = 1'b0;
    #1;
    chk("c_arst_valid", c_o_valid, 0);
    chk("c_arst_imm", c_o_imm, 0);
    chk("c_arst_tag", c_o_tag, 0);
    chk("c_arst_illegal", c_o_illegal, 0);
    chk("b_arst_valid", b_o_valid, 0);
    tick();
    i_rst_n = 1'b1;
    tick();
    chk("c_postrst_valid", c_o_valid, 0);
    c_ready = 1; c_valid = 1; c_tag = 5'd10; c_instr = mk_i(5'd10);
    #1;
    chk("c_postrst_ready", c_o_ready, 1);
    tick();
    c_valid = 0;
    tick();
    chk("c_postrst_latency", c_o_valid, 0);
    tick();
    chk("c_postrst_out_valid", c_o_valid, 1);
    chk("c_postrst_out_tag", c_o_tag, 10);
    chk("c_postrst_out_imm", c_o_imm, 10);
    tick();
    chk("c_postrst_drain", c_o_valid, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
